// File: rtl/uart_pkg.sv
// Shared definitions for the segment UART transmitter: byte-FSM states,
// ASCII constants and the bit-period helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  typedef struct packed {
    logic pend;
    logic val;
  } seg_slot_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. A byte is accepted while idle or in the last cycle of
// a stop bit, so consecutive bytes go out with no idle gap.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       active,
  output logic       done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e        state, state_n;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       shreg, shreg_n;
  logic             tx_n;
  logic             bit_end;

  assign bit_end = (baud_cnt == CNT_MAX);
  assign active  = (state != IDLE);
  assign done    = (state == STOP) && bit_end;

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    case (state)
      IDLE: begin
        if (start) begin
          state_n    = START;
          shreg_n    = data;
          baud_cnt_n = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n    = DATA;
          baud_cnt_n = '0;
          bit_cnt_n  = '0;
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          if (bit_cnt == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
            shreg_n   = {1'b0, shreg[7:1]};
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          if (start) begin
            state_n = START;
            shreg_n = data;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // line level is registered from the next state so tx never glitches
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      tx       <= tx_n;
    end
  end

endmodule

// File: rtl/uart_segment_tx.sv
// Captures segment requests on rising edges into single-depth slots and
// sequences them into ASCII bytes: segment 1 -> digit, segment 2 -> digit + LF.
module uart_segment_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic transmit_1,
  input  logic transmit_2,
  input  logic demod_1,
  input  logic demod_2,
  output logic tx,
  output logic busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

  logic       trig_1_q, trig_2_q;
  logic       rise_1, rise_2;
  seg_slot_t  slot_1, slot_2;
  logic       lf_pend;
  logic       byte_start, byte_active, byte_done, load;
  logic [7:0] byte_data;

  assign rise_1     = transmit_1 & ~trig_1_q;
  assign rise_2     = transmit_2 & ~trig_2_q;
  assign byte_start = lf_pend | slot_1.pend | slot_2.pend;
  assign load       = byte_start & (~byte_active | byte_done);
  assign busy       = byte_active | byte_start;

  // LF outranks segment 1 so the two segment-2 bytes stay back-to-back
  always_comb begin
    if (lf_pend)          byte_data = ASCII_LF;
    else if (slot_1.pend) byte_data = ASCII_ZERO + {7'd0, slot_1.val};
    else                  byte_data = ASCII_ZERO + {7'd0, slot_2.val};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_1_q <= 1'b0;
      trig_2_q <= 1'b0;
      slot_1   <= '0;
      slot_2   <= '0;
      lf_pend  <= 1'b0;
    end else begin
      trig_1_q <= transmit_1;
      trig_2_q <= transmit_2;
      if (load) begin
        if (lf_pend) begin
          lf_pend <= 1'b0;
        end else if (slot_1.pend) begin
          slot_1.pend <= 1'b0;
        end else begin
          slot_2.pend <= 1'b0;
          lf_pend     <= 1'b1;
        end
      end
      // a fresh edge wins over the clear above: newest value is re-armed
      if (rise_1) slot_1 <= '{pend: 1'b1, val: demod_1};
      if (rise_2) slot_2 <= '{pend: 1'b1, val: demod_2};
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk   (clk),
    .rst_n (rst_n),
    .start (byte_start),
    .data  (byte_data),
    .tx    (tx),
    .active(byte_active),
    .done  (byte_done)
  );

endmodule

// File: tb/tb_uart_segment_tx.sv
// Self-checking bench: table of request vectors plus hand sequences; a line
// monitor pops expected bytes from a scoreboard and checks every frame cycle.
module tb_uart_segment_tx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 70_000;
  localparam int CPB      = 14;  // 1_000_000 / 70_000, truncated

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic transmit_1 = 1'b0, transmit_2 = 1'b0;
  logic demod_1 = 1'b0, demod_2 = 1'b0;
  logic tx, busy;

  uart_segment_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .transmit_1(transmit_1), .transmit_2(transmit_2),
    .demod_1(demod_1), .demod_2(demod_2), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    bit         contig;
    bit         last;
  } exp_t;

  typedef struct {
    logic [1:0]      req;
    logic            d1;
    logic            d2;
    int              n;
    logic [2:0][7:0] b;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] d, input bit c, input bit l);
    exp_t e;
    e.data = d; e.contig = c; e.last = l;
    sb.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy !== 1'b0 || sb.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_timeout"}, 32'(n < 3000), 1);
    cycles(3 * CPB);
    chk({name, "_leftover"}, sb.size(), 0);
    chk({name, "_idle"}, {busy, tx}, 2'b01);
  endtask

  // line monitor: every cycle of a frame must match the expected 8N1 waveform
  initial begin : monitor
    exp_t       e;
    logic [9:0] frame;
    int         start_cyc, last_end, err_k;
    bit         aborted;
    last_end = -1000;
    forever begin
      @(negedge clk);
      if (rst_n && mon_en && tx === 1'b0) begin
        chk("frame_expected", 32'(sb.size() != 0), 1);
        if (sb.size() == 0) begin
          cycles(10 * CPB);
        end else begin
          e = sb.pop_front();
          frame = {1'b1, e.data, 1'b0};
          start_cyc = cyc;
          err_k = -1;
          aborted = 1'b0;
          if (e.contig) chk("contiguous_start", start_cyc, last_end + 1);
          for (int k = 0; k < 10 * CPB; k++) begin
            if (k > 0) @(negedge clk);
            if (!rst_n) begin
              aborted = 1'b1;
              break;
            end
            if (err_k < 0 && (tx !== frame[k / CPB] || busy !== 1'b1)) err_k = k;
          end
          chk($sformatf("frame_%02h_abort", e.data), 32'(aborted), 0);
          chk($sformatf("frame_%02h_first_bad_cycle", e.data), err_k, -1);
          last_end = cyc;
          if (e.last) begin
            @(negedge clk);
            chk("busy_drop_after_stop", {tx, busy}, 2'b10);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #800_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  vec_t vecs[6];
  int   errs;
  int   abort_pts[2];

  initial begin : stim
    vecs[0] = '{req: 2'b01, d1: 1'b1, d2: 1'b0, n: 1, b: {8'h00, 8'h00, 8'h31}};
    vecs[1] = '{req: 2'b01, d1: 1'b0, d2: 1'b1, n: 1, b: {8'h00, 8'h00, 8'h30}};
    vecs[2] = '{req: 2'b10, d1: 1'b0, d2: 1'b1, n: 2, b: {8'h00, 8'h0A, 8'h31}};
    vecs[3] = '{req: 2'b10, d1: 1'b1, d2: 1'b0, n: 2, b: {8'h00, 8'h0A, 8'h30}};
    vecs[4] = '{req: 2'b11, d1: 1'b1, d2: 1'b0, n: 3, b: {8'h0A, 8'h30, 8'h31}};
    vecs[5] = '{req: 2'b11, d1: 1'b0, d2: 1'b1, n: 3, b: {8'h0A, 8'h31, 8'h30}};

    // reset state and long idle
    cycles(3);
    chk("reset_outputs", {tx, busy}, 2'b10);
    rst_n = 1'b1;
    errs = 0;
    repeat (10000) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) errs++;
    end
    chk("idle_10000", errs, 0);

    // table-driven request vectors
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < vecs[v].n; i++) push(vecs[v].b[i], i > 0, i == vecs[v].n - 1);
      demod_1 = vecs[v].d1;
      demod_2 = vecs[v].d2;
      transmit_1 = vecs[v].req[0];
      transmit_2 = vecs[v].req[1];
      @(negedge clk);
      chk($sformatf("vec%0d_busy_rise", v), busy, 1);
      @(negedge clk);
      chk($sformatf("vec%0d_start_latency", v), tx, 0);
      demod_1 = ~vecs[v].d1;  // captured value must not follow later changes
      demod_2 = ~vecs[v].d2;
      cycles(200);            // held high past the frame: no retrigger
      transmit_1 = 1'b0;
      transmit_2 = 1'b0;
      wait_idle($sformatf("vec%0d", v));
    end

    // controller sequence: seg 1 then seg 2 while seg 1 shifts
    push(8'h30, 0, 0); push(8'h31, 1, 0); push(8'h0A, 1, 1);
    demod_1 = 1'b0; demod_2 = 1'b1;
    transmit_1 = 1'b1; cycles(20); transmit_1 = 1'b0;
    cycles(20);
    transmit_2 = 1'b1; cycles(200); transmit_2 = 1'b0;
    wait_idle("ctrl_seq");

    // second seg-2 edge while still pending: newest value, sent once
    push(8'h30, 0, 0); push(8'h31, 1, 0); push(8'h0A, 1, 1);
    demod_1 = 1'b0;
    transmit_1 = 1'b1; cycles(10); transmit_1 = 1'b0;
    demod_2 = 1'b0; transmit_2 = 1'b1; cycles(10); transmit_2 = 1'b0;
    cycles(10);
    demod_2 = 1'b1; transmit_2 = 1'b1; cycles(10); transmit_2 = 1'b0;
    wait_idle("overwrite");

    // same segment re-requested while shifting: queued behind current byte
    push(8'h31, 0, 0); push(8'h30, 1, 1);
    demod_1 = 1'b1; transmit_1 = 1'b1; cycles(10); transmit_1 = 1'b0;
    cycles(40);
    demod_1 = 1'b0; transmit_1 = 1'b1; cycles(10); transmit_1 = 1'b0;
    wait_idle("resend");

    // seg 1 arriving mid seg-2 must not split digit and LF
    push(8'h31, 0, 0); push(8'h0A, 1, 0); push(8'h30, 1, 1);
    demod_2 = 1'b1; transmit_2 = 1'b1; cycles(10); transmit_2 = 1'b0;
    demod_1 = 1'b0; transmit_1 = 1'b1; cycles(10); transmit_1 = 1'b0;
    wait_idle("lf_first");

    // reset mid-frame: during start bit and during data bit 4
    abort_pts[0] = CPB / 2;
    abort_pts[1] = 5 * CPB + CPB / 2;
    for (int a = 0; a < 2; a++) begin
      mon_en = 1'b0;
      demod_1 = 1'b0;
      transmit_1 = 1'b1;
      cycles(2);
      cycles(abort_pts[a]);
      transmit_1 = 1'b0;
      chk($sformatf("abort%0d_busy_before", a), busy, 1);
      rst_n = 1'b0;
      #1;
      chk($sformatf("abort%0d_immediate", a), {tx, busy}, 2'b10);
      errs = 0;
      repeat (100) begin
        @(negedge clk);
        if (tx !== 1'b1 || busy !== 1'b0) errs++;
      end
      rst_n = 1'b1;
      mon_en = 1'b1;
      repeat (20 * CPB) begin
        @(negedge clk);
        if (tx !== 1'b1 || busy !== 1'b0) errs++;
      end
      chk($sformatf("abort%0d_no_resume", a), errs, 0);
    end

    // request held high across reset release counts as an edge
    rst_n = 1'b0;
    demod_1 = 1'b1;
    transmit_1 = 1'b1;
    cycles(3);
    push(8'h31, 0, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("held_reset_edge_busy", busy, 1);
    cycles(5);
    transmit_1 = 1'b0;
    wait_idle("held_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
